// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture serializer.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SNAP = 3'd1,
    S_HDR  = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [3:0] HDR_MARKER = 4'hA;

  // Header word: marker in the top nibble, channel index in the LSBs, zeros between.
  // Returned 32 bits wide; callers truncate to their pad width (<= 32).
  function automatic logic [31:0] hdr_word(input int unsigned out_w, input int unsigned idx);
    hdr_word = (32'(HDR_MARKER) << (out_w - 32'd4)) | 32'(idx);
  endfunction

endpackage

// File: rtl/adc_capture_serializer_if.sv
// ADC sample, config, control and pad-side signals of the capture serializer.
interface adc_capture_serializer_if #(
  parameter int unsigned NUM_CH    = 48,
  parameter int unsigned CH_WIDTH  = 36,
  parameter int unsigned OUT_WIDTH = 18,
  parameter int unsigned IDLE_W    = 16
);

  logic [NUM_CH*CH_WIDTH-1:0] adc_data;
  logic [NUM_CH-1:0]          cfg_ch_mask;
  logic [IDLE_W-1:0]          cfg_idle_len;
  logic                       capture_start;
  logic                       capture_again;
  logic                       rd_en;
  logic [OUT_WIDTH-1:0]       out_data;
  logic                       out_valid;
  logic                       busy;
  logic                       done;

  modport master (
    output adc_data, cfg_ch_mask, cfg_idle_len, capture_start, capture_again, rd_en,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  adc_data, cfg_ch_mask, cfg_idle_len, capture_start, capture_again, rd_en,
    output out_data, out_valid, busy, done
  );

endinterface

// File: rtl/adc_capture_serializer_ch_next_finder.sv
// Combinational search for the lowest set mask bit at or above from_i.
module ch_next_finder #(
  parameter int unsigned NUM_CH = 48,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [IDX_W:0]    from_i,
  output logic [IDX_W-1:0]  idx_c_o,
  output logic              found_c_o
);

  logic [IDX_W-1:0] idx_v;
  logic             found_v;

  // Priority scan from LSB; first qualifying bit wins.
  always_comb begin
    idx_v   = '0;
    found_v = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found_v && mask_i[i] && (i >= 32'(from_i))) begin
        found_v = 1'b1;
        idx_v   = IDX_W'(i);
      end
    end
  end

  assign idx_c_o   = idx_v;
  assign found_c_o = found_v;

endmodule

// File: rtl/adc_capture_serializer.sv
// Snapshots NUM_CH ADC channels and streams enabled ones as framed packets on the pad bus.
module adc_capture_serializer
  import adc_capture_pkg::*;
#(
  parameter int unsigned NUM_CH    = 48,
  parameter int unsigned CH_WIDTH  = 36,
  parameter int unsigned OUT_WIDTH = 18,
  parameter int unsigned IDLE_W    = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  adc_capture_serializer_if.slave   bus
);

  localparam int unsigned WPC      = CH_WIDTH / OUT_WIDTH;
  localparam int unsigned CH_IDX_W = $clog2(NUM_CH);
  localparam int unsigned WCNT_W   = (WPC > 1) ? $clog2(WPC) : 1;

  state_e                     state_q, state_d;
  logic [NUM_CH*CH_WIDTH-1:0] snap_q;
  logic                       snap_vld_q, snap_vld_d;
  logic                       snap_load_c;
  logic [CH_IDX_W-1:0]        ch_idx_q, ch_idx_d;
  logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
  logic [IDLE_W-1:0]          gcnt_q, gcnt_d;
  logic [OUT_WIDTH-1:0]       out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       adv_ch_c;

  logic [CH_IDX_W-1:0]        first_idx_c, nxt_idx_c;
  logic                       first_found_c, nxt_found_c;
  logic [CH_WIDTH-1:0]        cur_ch_c;
  logic [OUT_WIDTH-1:0]       cur_word_c;
  logic [OUT_WIDTH-1:0]       hdr_c;

  // First enabled channel, searched from index 0.
  ch_next_finder #(.NUM_CH(NUM_CH), .IDX_W(CH_IDX_W)) u_first (
    .mask_i    (bus.cfg_ch_mask),
    .from_i    ('0),
    .idx_c_o   (first_idx_c),
    .found_c_o (first_found_c)
  );

  // Next enabled channel strictly above the current one.
  ch_next_finder #(.NUM_CH(NUM_CH), .IDX_W(CH_IDX_W)) u_next (
    .mask_i    (bus.cfg_ch_mask),
    .from_i    ((CH_IDX_W+1)'(ch_idx_q) + (CH_IDX_W+1)'(1)),
    .idx_c_o   (nxt_idx_c),
    .found_c_o (nxt_found_c)
  );

  // Current channel sample and its MSB-first data word.
  assign cur_ch_c   = CH_WIDTH'(snap_q >> (32'(ch_idx_q) * CH_WIDTH));
  assign cur_word_c = OUT_WIDTH'(cur_ch_c >> (CH_WIDTH - OUT_WIDTH * (32'(wcnt_q) + 32'd1)));
  assign hdr_c      = OUT_WIDTH'(hdr_word(OUT_WIDTH, 32'(ch_idx_q)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    snap_vld_d  = snap_vld_q;
    snap_load_c = 1'b0;
    ch_idx_d    = ch_idx_q;
    wcnt_d      = wcnt_q;
    gcnt_d      = gcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    adv_ch_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.capture_start) begin
          state_d = S_SNAP;
        end else if (bus.capture_again && snap_vld_q) begin
          if (first_found_c) begin
            state_d  = S_HDR;
            ch_idx_d = first_idx_c;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SNAP: begin
        snap_load_c = 1'b1;
        snap_vld_d  = 1'b1;
        if (first_found_c) begin
          state_d  = S_HDR;
          ch_idx_d = first_idx_c;
        end else begin
          state_d = S_DONE;
        end
      end
      S_HDR: begin
        if (bus.rd_en) begin
          out_data_d  = hdr_c;
          out_valid_d = 1'b1;
          wcnt_d      = '0;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.rd_en) begin
          out_data_d  = cur_word_c;
          out_valid_d = 1'b1;
          if (wcnt_q == WCNT_W'(WPC - 1)) begin
            if (bus.cfg_idle_len != '0) begin
              state_d = S_GAP;
              gcnt_d  = '0;
            end else begin
              adv_ch_c = 1'b1;
            end
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (bus.rd_en) begin
          out_data_d = '0;
          if (gcnt_q == (bus.cfg_idle_len - IDLE_W'(1))) begin
            adv_ch_c = 1'b1;
          end else begin
            gcnt_d = gcnt_q + IDLE_W'(1);
          end
        end
      end
      S_DONE: begin
        done_d     = 1'b1;
        out_data_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv_ch_c) begin
      if (nxt_found_c) begin
        state_d  = S_HDR;
        ch_idx_d = nxt_idx_c;
      end else begin
        state_d = S_DONE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      snap_vld_q  <= 1'b0;
      ch_idx_q    <= '0;
      wcnt_q      <= '0;
      gcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_vld_q  <= snap_vld_d;
      ch_idx_q    <= ch_idx_d;
      wcnt_q      <= wcnt_d;
      gcnt_q      <= gcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Snapshot register, loaded only in SNAP.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      snap_q <= '0;
    end else if (snap_load_c) begin
      snap_q <= bus.adc_data;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
